// File: rtl/dm_sba_regs.sv
// ---------------------------------------------------------------------------
// dm_sba_regs
//
// DMI-facing register file for system bus access. Holds sbcs (0x38),
// sbaddress0 (0x39) and sbdata0 (0x3C), decodes DMI read/write requests,
// applies busy and error gating, and emits single-cycle access triggers to
// the downstream bus-access controller. Read data, auto-incremented
// addresses and bus errors reported by that controller are absorbed here.
//
// Ports
//   clk_i, rst_ni                     clock, synchronous active-low reset
//   dmactive_i                        low clears all state at the clock edge
//   dmi_req_*                         DMI request (op 1=read, 2=write)
//   dmi_resp_*                        registered single-entry response
//   sbaddress_o, sbdata_o             current register values
//   sbreadonaddr_o, sbautoincrement_o,
//   sbaccess_o, sbreadondata_o        sbcs control fields
//   sbaddress_write_valid_o           read-on-address trigger pulse
//   sbdata_read_valid_o               read-on-data trigger pulse
//   sbdata_write_valid_o              bus write trigger pulse
//   sbbusy_i                          controller busy
//   sbaddress_next_i/_update_i        auto-increment address load
//   sbdata_i/sbdata_valid_i           bus read data load
//   sberror_i/sberror_valid_i         bus error report
// ---------------------------------------------------------------------------
module dm_sba_regs #(
    parameter int unsigned SbVersion = 1,
    parameter int unsigned SbaSize   = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dmactive_i,
    input  logic        dmi_req_valid_i,
    output logic        dmi_req_ready_o,
    input  logic [6:0]  dmi_req_addr_i,
    input  logic [1:0]  dmi_req_op_i,
    input  logic [31:0] dmi_req_data_i,
    output logic        dmi_resp_valid_o,
    input  logic        dmi_resp_ready_i,
    output logic [31:0] dmi_resp_data_o,
    output logic [31:0] sbaddress_o,
    output logic        sbaddress_write_valid_o,
    output logic        sbreadonaddr_o,
    output logic        sbautoincrement_o,
    output logic [2:0]  sbaccess_o,
    output logic        sbreadondata_o,
    output logic [31:0] sbdata_o,
    output logic        sbdata_read_valid_o,
    output logic        sbdata_write_valid_o,
    input  logic        sbbusy_i,
    input  logic [31:0] sbaddress_next_i,
    input  logic        sbaddress_update_i,
    input  logic [31:0] sbdata_i,
    input  logic        sbdata_valid_i,
    input  logic        sberror_valid_i,
    input  logic [2:0]  sberror_i
);

    localparam logic [6:0] ADDR_SBCS       = 7'h38;
    localparam logic [6:0] ADDR_SBADDRESS0 = 7'h39;
    localparam logic [6:0] ADDR_SBDATA0    = 7'h3C;
    localparam logic [1:0] OP_READ         = 2'd1;
    localparam logic [1:0] OP_WRITE        = 2'd2;
    localparam logic [2:0] SB_VERSION      = 3'(SbVersion);
    localparam logic [6:0] SBA_SIZE        = 7'(SbaSize);

    // Returns the sberror code an access would raise, or 0 if it may proceed.
    function automatic logic [2:0] access_error(input logic [2:0] access, input logic [31:0] addr);
        logic [31:0] mask;
        if (access > 3'd2) return 3'd4;
        mask = (32'd1 << access) - 32'd1;
        if ((addr & mask) != 32'd0) return 3'd3;
        return 3'd0;
    endfunction

    logic [31:0] sbaddress_q, sbaddress_d;
    logic [31:0] sbdata_q, sbdata_d;
    logic        sbbusyerror_q, sbbusyerror_d;
    logic        sbreadonaddr_q, sbreadonaddr_d;
    logic [2:0]  sbaccess_q, sbaccess_d;
    logic        sbautoincrement_q, sbautoincrement_d;
    logic        sbreadondata_q, sbreadondata_d;
    logic [2:0]  sberror_q, sberror_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        addr_trig_q, addr_trig_d;
    logic        rd_trig_q, rd_trig_d;
    logic        wr_trig_q, wr_trig_d;

    logic        req_fire, is_read, is_write, sbcs_write, err_w1c;
    logic        trig_q, busy_eff, can_trigger;
    logic [2:0]  chk_err;
    logic [31:0] sbcs_value;

    assign dmi_req_ready_o = !resp_valid_q || dmi_resp_ready_i;
    assign req_fire        = dmi_req_valid_i && dmi_req_ready_o;
    assign is_read         = req_fire && (dmi_req_op_i == OP_READ);
    assign is_write        = req_fire && (dmi_req_op_i == OP_WRITE);
    assign sbcs_write      = is_write && (dmi_req_addr_i == ADDR_SBCS);
    assign err_w1c         = sbcs_write && (dmi_req_data_i[14:12] != 3'd0);

    // A trigger issued last edge has not yet raised sbbusy_i at the
    // controller, so the pulse itself counts as busy for that cycle.
    assign trig_q      = addr_trig_q | rd_trig_q | wr_trig_q;
    assign busy_eff    = sbbusy_i | trig_q;
    assign can_trigger = (sberror_q == 3'd0) && !sbbusyerror_q;

    assign sbcs_value = {SB_VERSION, 6'b0, sbbusyerror_q, busy_eff, sbreadonaddr_q,
                         sbaccess_q, sbautoincrement_q, sbreadondata_q, sberror_q,
                         SBA_SIZE, 5'b00111};

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        sbaddress_d       = sbaddress_q;
        sbdata_d          = sbdata_q;
        sbbusyerror_d     = sbbusyerror_q;
        sbreadonaddr_d    = sbreadonaddr_q;
        sbaccess_d        = sbaccess_q;
        sbautoincrement_d = sbautoincrement_q;
        sbreadondata_d    = sbreadondata_q;
        sberror_d         = sberror_q;
        resp_valid_d      = resp_valid_q;
        resp_data_d       = resp_data_q;
        addr_trig_d       = 1'b0;
        rd_trig_d         = 1'b0;
        wr_trig_d         = 1'b0;
        chk_err           = 3'd0;

        if (resp_valid_q && dmi_resp_ready_i) resp_valid_d = 1'b0;
        if (is_read || is_write) begin
            resp_valid_d = 1'b1;
            resp_data_d  = 32'd0;
        end

        if (is_read) begin
            case (dmi_req_addr_i)
                ADDR_SBCS:       resp_data_d = sbcs_value;
                ADDR_SBADDRESS0: resp_data_d = sbaddress_q;
                ADDR_SBDATA0: begin
                    // Always returns the pre-access value; a triggered read
                    // refreshes sbdata0 later via sbdata_valid_i.
                    resp_data_d = sbdata_q;
                    if (busy_eff) begin
                        sbbusyerror_d = 1'b1;
                    end else if (sbreadondata_q && can_trigger) begin
                        chk_err = access_error(sbaccess_q, sbaddress_q);
                        if (chk_err != 3'd0) sberror_d = chk_err;
                        else                 rd_trig_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (is_write) begin
            case (dmi_req_addr_i)
                ADDR_SBCS: begin
                    sbbusyerror_d     = sbbusyerror_q & ~dmi_req_data_i[22];
                    sbreadonaddr_d    = dmi_req_data_i[20];
                    sbaccess_d        = dmi_req_data_i[19:17];
                    sbautoincrement_d = dmi_req_data_i[16];
                    sbreadondata_d    = dmi_req_data_i[15];
                    sberror_d         = sberror_q & ~dmi_req_data_i[14:12];
                end
                ADDR_SBADDRESS0: begin
                    if (busy_eff) begin
                        sbbusyerror_d = 1'b1;
                    end else begin
                        sbaddress_d = dmi_req_data_i;
                        if (sbreadonaddr_q && can_trigger) begin
                            chk_err = access_error(sbaccess_q, dmi_req_data_i);
                            if (chk_err != 3'd0) sberror_d   = chk_err;
                            else                 addr_trig_d = 1'b1;
                        end
                    end
                end
                ADDR_SBDATA0: begin
                    if (busy_eff) begin
                        sbbusyerror_d = 1'b1;
                    end else begin
                        sbdata_d = dmi_req_data_i;
                        if (can_trigger) begin
                            chk_err = access_error(sbaccess_q, sbaddress_q);
                            if (chk_err != 3'd0) sberror_d = chk_err;
                            else                 wr_trig_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Controller updates take precedence over DMI writes.
        if (sbdata_valid_i)     sbdata_d    = sbdata_i;
        if (sbaddress_update_i) sbaddress_d = sbaddress_next_i;
        // First error is sticky, unless software clears it in this same cycle.
        if (sberror_valid_i && ((sberror_q == 3'd0) || err_w1c)) sberror_d = sberror_i;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        // NOTE: every register, including response data, is cleared so that
        // nothing stale survives a debug-module deactivation.
        if (!rst_ni || !dmactive_i) begin
            sbaddress_q       <= 32'd0;
            sbdata_q          <= 32'd0;
            sbbusyerror_q     <= 1'b0;
            sbreadonaddr_q    <= 1'b0;
            sbaccess_q        <= 3'b010;
            sbautoincrement_q <= 1'b0;
            sbreadondata_q    <= 1'b0;
            sberror_q         <= 3'd0;
            resp_valid_q      <= 1'b0;
            resp_data_q       <= 32'd0;
            addr_trig_q       <= 1'b0;
            rd_trig_q         <= 1'b0;
            wr_trig_q         <= 1'b0;
        end else begin
            sbaddress_q       <= sbaddress_d;
            sbdata_q          <= sbdata_d;
            sbbusyerror_q     <= sbbusyerror_d;
            sbreadonaddr_q    <= sbreadonaddr_d;
            sbaccess_q        <= sbaccess_d;
            sbautoincrement_q <= sbautoincrement_d;
            sbreadondata_q    <= sbreadondata_d;
            sberror_q         <= sberror_d;
            resp_valid_q      <= resp_valid_d;
            resp_data_q       <= resp_data_d;
            addr_trig_q       <= addr_trig_d;
            rd_trig_q         <= rd_trig_d;
            wr_trig_q         <= wr_trig_d;
        end
    end

    assign dmi_resp_valid_o        = resp_valid_q;
    assign dmi_resp_data_o         = resp_data_q;
    assign sbaddress_o             = sbaddress_q;
    assign sbdata_o                = sbdata_q;
    assign sbreadonaddr_o          = sbreadonaddr_q;
    assign sbautoincrement_o       = sbautoincrement_q;
    assign sbaccess_o              = sbaccess_q;
    assign sbreadondata_o          = sbreadondata_q;
    assign sbaddress_write_valid_o = addr_trig_q;
    assign sbdata_read_valid_o     = rd_trig_q;
    assign sbdata_write_valid_o    = wr_trig_q;

endmodule
